// File: rtl/error_statistics.sv
// Batch statistics over a residual stream: sum of squares, max |error|, mean, and over-threshold count.
// The mean comes from a sequential restoring divider that retires one quotient bit per cycle.
module error_statistics #(
    parameter int DATA_WIDTH   = 20,
    parameter int SAMPLE_COUNT = 150,
    parameter int CNT_WIDTH    = 8,
    parameter int SUM_WIDTH    = 28,
    parameter int ACC_WIDTH    = 48
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] threshold,
    input  logic                  error_valid,
    input  logic [DATA_WIDTH-1:0] error,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_WIDTH-1:0]  sum_sq_error,
    output logic [DATA_WIDTH-1:0] max_abs_error,
    output logic [DATA_WIDTH-1:0] mean_error,
    output logic [CNT_WIDTH-1:0]  over_count
);

    localparam int DIV_CNT_WIDTH = $clog2(SUM_WIDTH + 1);
    localparam int SQ_WIDTH      = 2 * DATA_WIDTH;
    localparam int REM_WIDTH     = CNT_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DIVIDE,
        DONE
    } state_t;

    state_t state, next_state;

    logic [DATA_WIDTH-1:0]    thresh_q;
    logic [CNT_WIDTH-1:0]     sample_cnt;
    logic [SUM_WIDTH-1:0]     sum_q;
    logic [SUM_WIDTH-1:0]     div_q;
    logic [CNT_WIDTH-1:0]     div_r;
    logic [DIV_CNT_WIDTH-1:0] div_cnt;
    logic                     div_neg;

    logic [DATA_WIDTH-1:0] abs_err;
    logic [SQ_WIDTH-1:0]   sq_err;
    logic [SUM_WIDTH-1:0]  err_ext;
    logic [SUM_WIDTH-1:0]  sum_next;
    logic [SUM_WIDTH-1:0]  sum_mag;
    logic                  sample_take;
    logic                  last_sample;
    logic [REM_WIDTH-1:0]  div_trial;
    logic                  div_ge;
    logic [CNT_WIDTH-1:0]  div_r_next;
    logic [SUM_WIDTH-1:0]  div_q_next;
    logic                  div_last;
    logic [DATA_WIDTH-1:0] quot_lo;
    logic [DATA_WIDTH-1:0] mean_next;

    // Magnitude is unsigned DATA_WIDTH, so the most negative residual maps to 2^(DATA_WIDTH-1).
    always_comb begin
        abs_err     = error[DATA_WIDTH-1] ? (~error + DATA_WIDTH'(1)) : error;
        sq_err      = SQ_WIDTH'(abs_err) * SQ_WIDTH'(abs_err);
        err_ext     = {{(SUM_WIDTH-DATA_WIDTH){error[DATA_WIDTH-1]}}, error};
        sum_next    = sum_q + err_ext;
        sum_mag     = sum_next[SUM_WIDTH-1] ? (~sum_next + SUM_WIDTH'(1)) : sum_next;
        sample_take = (state == ACCUM) && error_valid;
        last_sample = sample_take && (sample_cnt == CNT_WIDTH'(SAMPLE_COUNT - 1));
    end

    always_comb begin
        div_trial  = {div_r, div_q[SUM_WIDTH-1]};
        div_ge     = div_trial >= REM_WIDTH'(SAMPLE_COUNT);
        div_r_next = div_ge ? CNT_WIDTH'(div_trial - REM_WIDTH'(SAMPLE_COUNT))
                            : div_trial[CNT_WIDTH-1:0];
        div_q_next = {div_q[SUM_WIDTH-2:0], div_ge};
        div_last   = div_cnt == DIV_CNT_WIDTH'(SUM_WIDTH);
        quot_lo    = div_q[DATA_WIDTH-1:0];
        mean_next  = div_neg ? (~quot_lo + DATA_WIDTH'(1)) : quot_lo;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = ACCUM;
                end
            end
            ACCUM: begin
                busy = 1'b1;
                if (last_sample) begin
                    next_state = DIVIDE;
                end
            end
            DIVIDE: begin
                busy = 1'b1;
                if (div_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            thresh_q      <= '0;
            sample_cnt    <= '0;
            sum_q         <= '0;
            div_q         <= '0;
            div_r         <= '0;
            div_cnt       <= '0;
            div_neg       <= 1'b0;
            sum_sq_error  <= '0;
            max_abs_error <= '0;
            mean_error    <= '0;
            over_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        thresh_q      <= threshold;
                        sample_cnt    <= '0;
                        sum_q         <= '0;
                        sum_sq_error  <= '0;
                        max_abs_error <= '0;
                        mean_error    <= '0;
                        over_count    <= '0;
                    end
                end
                ACCUM: begin
                    if (sample_take) begin
                        sum_q        <= sum_next;
                        sum_sq_error <= sum_sq_error + ACC_WIDTH'(sq_err);
                        sample_cnt   <= sample_cnt + CNT_WIDTH'(1);
                        if (abs_err > max_abs_error) begin
                            max_abs_error <= abs_err;
                        end
                        if (abs_err > thresh_q) begin
                            over_count <= over_count + CNT_WIDTH'(1);
                        end
                        // Divider is seeded from the final sum on the same edge that takes the last sample.
                        if (last_sample) begin
                            div_q   <= sum_mag;
                            div_r   <= '0;
                            div_cnt <= '0;
                            div_neg <= sum_next[SUM_WIDTH-1];
                        end
                    end
                end
                DIVIDE: begin
                    if (div_last) begin
                        mean_error <= mean_next;
                    end else begin
                        div_q   <= div_q_next;
                        div_r   <= div_r_next;
                        div_cnt <= div_cnt + DIV_CNT_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_error_statistics.sv
// Self-checking bench for error_statistics: batch-level reference model plus literal scenario checks.
module tb_error_statistics;

    localparam int DW = 20;
    localparam int SC = 150;
    localparam int CW = 8;
    localparam int SW = 28;
    localparam int AW = 48;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] threshold = '0;
    logic          error_valid = 1'b0;
    logic [DW-1:0] error = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] sum_sq_error;
    logic [DW-1:0] max_abs_error;
    logic [DW-1:0] mean_error;
    logic [CW-1:0] over_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_pulses = 0;

    error_statistics #(
        .DATA_WIDTH  (DW),
        .SAMPLE_COUNT(SC),
        .CNT_WIDTH   (CW),
        .SUM_WIDTH   (SW),
        .ACC_WIDTH   (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .threshold    (threshold),
        .error_valid  (error_valid),
        .error        (error),
        .busy         (busy),
        .done         (done),
        .sum_sq_error (sum_sq_error),
        .max_abs_error(max_abs_error),
        .mean_error   (mean_error),
        .over_count   (over_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: remembers the accepted samples of the current batch and a phase.
    // Phase 0 idle, 1 collecting, 2 waiting for the divider, 3 done cycle.
    int            m_phase = 0;
    int            m_n = 0;
    int            m_wait = 0;
    logic [DW-1:0] m_thr = '0;
    logic [DW-1:0] m_mean = '0;
    logic [DW-1:0] m_samp [SC];

    function automatic longint samp_val(input int i);
        return longint'($signed(m_samp[i]));
    endfunction

    function automatic longint samp_abs(input int i);
        longint v;
        v = samp_val(i);
        return (v < 0) ? -v : v;
    endfunction

    function automatic longint exp_sumsq();
        longint s = 0;
        for (int i = 0; i < m_n; i++) s += samp_abs(i) * samp_abs(i);
        return s;
    endfunction

    function automatic longint exp_max();
        longint m = 0;
        for (int i = 0; i < m_n; i++) if (samp_abs(i) > m) m = samp_abs(i);
        return m;
    endfunction

    function automatic longint exp_over();
        longint c = 0;
        for (int i = 0; i < m_n; i++) if (samp_abs(i) > longint'(m_thr)) c++;
        return c;
    endfunction

    function automatic logic [DW-1:0] exp_mean();
        longint s = 0;
        for (int i = 0; i < SC; i++) s += samp_val(i);
        return DW'(s / SC);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase <= 0;
            m_n     <= 0;
            m_wait  <= 0;
            m_thr   <= '0;
            m_mean  <= '0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_n     <= 0;
                    m_mean  <= '0;
                    m_thr   <= threshold;
                    m_phase <= 1;
                end
                1: if (error_valid) begin
                    m_samp[m_n] <= error;
                    m_n         <= m_n + 1;
                    if (m_n == SC - 1) begin
                        m_phase <= 2;
                        m_wait  <= 0;
                    end
                end
                2: begin
                    m_wait <= m_wait + 1;
                    if (m_wait == SW) begin
                        m_mean  <= exp_mean();
                        m_phase <= 3;
                    end
                end
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("busy", longint'(busy), longint'(m_phase == 1 || m_phase == 2));
        check("done", longint'(done), longint'(m_phase == 3));
        check("sum_sq_error", longint'(sum_sq_error), exp_sumsq());
        check("max_abs_error", longint'(max_abs_error), exp_max());
        check("over_count", longint'(over_count), exp_over());
        check("mean_error", longint'($signed(mean_error)), longint'($signed(m_mean)));
        if (done) done_pulses++;
    end

    task automatic do_start(input logic [DW-1:0] thr, input logic ev, input logic [DW-1:0] ev_data);
        @(negedge clk);
        start       = 1'b1;
        threshold   = thr;
        error_valid = ev;
        error       = ev_data;
        @(negedge clk);
        start       = 1'b0;
        error_valid = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] v, input int gap);
        repeat (gap) begin
            @(negedge clk);
            error_valid = 1'b0;
        end
        @(negedge clk);
        error_valid = 1'b1;
        error       = v;
    endtask

    // Optionally drives start/error_valid noise while the divider runs, then waits for done.
    task automatic end_batch(input int noise, output int lat);
        int n_edge;
        int k;
        @(negedge clk);
        n_edge      = cyc;
        error_valid = (noise > 0);
        start       = (noise > 0);
        error       = 20'd100;
        repeat (noise) @(negedge clk);
        error_valid = 1'b0;
        start       = 1'b0;
        k = 0;
        while (!done && k < 80) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", longint'(done), 1);
        lat = cyc - n_edge;
    endtask

    task automatic check_results(input string tag, input longint sq, input longint mx,
                                 input longint mean, input longint ov);
        check({tag, "_sum_sq"}, longint'(sum_sq_error), sq);
        check({tag, "_max_abs"}, longint'(max_abs_error), mx);
        check({tag, "_mean"}, longint'($signed(mean_error)), mean);
        check({tag, "_over"}, longint'(over_count), ov);
    endtask

    initial begin
        int lat;
        int p0;

        repeat (3) @(negedge clk);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check_results("rst", 0, 0, 0, 0);
        reset = 1'b1;

        // 1: constant +3, continuous valid, latency pinned
        do_start(20'd2, 1'b0, '0);
        for (int i = 0; i < SC; i++) send(20'd3, 0);
        end_batch(0, lat);
        check("s1_latency", lat, 29);
        check_results("s1", 1350, 3, 3, 150);
        repeat (3) @(negedge clk);
        check("s1_hold_mean", longint'($signed(mean_error)), 3);

        // 2: alternating +5/-5 with random gaps
        do_start(20'd5, 1'b0, '0);
        for (int i = 0; i < SC; i++) send((i % 2 == 0) ? 20'd5 : 20'hFFFFB, $urandom_range(0, 3));
        end_batch(0, lat);
        check_results("s2", 3750, 5, 0, 0);

        // 3: constant -7, threshold 0
        do_start(20'd0, 1'b0, '0);
        for (int i = 0; i < SC; i++) send(20'hFFFF9, 0);
        end_batch(0, lat);
        check_results("s3", 7350, 7, -7, 150);
        check("s3_mean_bits", longint'(mean_error), longint'(20'hFFFF9));

        // 4: most negative residual once, then zeros
        do_start(20'd524287, 1'b0, '0);
        send(20'h80000, 0);
        for (int i = 1; i < SC; i++) send(20'd0, 0);
        end_batch(0, lat);
        check_results("s4", 64'd274877906944, 524288, -3495, 1);

        // 5: reset in the middle of accumulation
        do_start(20'd0, 1'b0, '0);
        for (int i = 0; i < 50; i++) send(20'd9, 0);
        @(negedge clk);
        error_valid = 1'b0;
        #2 reset = 1'b0;
        p0 = done_pulses;
        @(negedge clk);
        check("s5_busy", longint'(busy), 0);
        check_results("s5_rst", 0, 0, 0, 0);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("s5_no_done", longint'(done_pulses - p0), 0);
        do_start(20'd3, 1'b0, '0);
        for (int i = 0; i < SC; i++) send(20'd1, 0);
        end_batch(0, lat);
        check_results("s5", 150, 1, 1, 0);

        // 6: stray start/error_valid in IDLE, ACCUM and DIVIDE
        repeat (3) send(20'd1000, 0);
        p0 = done_pulses;
        do_start(20'd2, 1'b1, 20'd999);
        for (int i = 0; i < SC; i++) begin
            send(20'd3, 0);
            start = (i == 40 || i == 41);
        end
        start = 1'b0;
        end_batch(10, lat);
        check_results("s6", 1350, 3, 3, 150);
        repeat (4) @(negedge clk);
        check("s6_one_done", longint'(done_pulses - p0), 1);
        check("s6_idle_busy", longint'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
